// File: rtl/arilla_bus_pkg.sv
// -----------------------------------------------------------------------------
// arilla_bus_pkg
//   Shared types and helpers for the arilla bus arbiter.
//   - arb_state_e : arbiter ownership state (idle / owned / locked)
//   - rr_pick_t   : result of a round-robin scan (found flag + winning index)
//   - rr_next()   : first set request bit strictly after a pointer, wrapping
//                   modulo the number of masters (the pointer itself is last)
// -----------------------------------------------------------------------------
package arilla_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    // Upper bound on the number of masters the scan helper supports.
    localparam int unsigned RR_MAX_MASTERS = 32;
    localparam int unsigned RR_IDX_W       = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan req starting at ptr+1, wrapping at n, ending with ptr itself.
    // ptr must be < n; only the low n bits of req are considered.
    function automatic rr_pick_t rr_next(input logic [RR_MAX_MASTERS-1:0] req,
                                         input logic [RR_IDX_W-1:0]       ptr,
                                         input int unsigned               n);
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 1; k <= RR_MAX_MASTERS; k++) begin
            // ptr < n and k <= n, so a single subtraction performs the wrap.
            cand = 32'(ptr) + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if ((k <= n) && !pick.found && req[cand[RR_IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[RR_IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage : arilla_bus_pkg

// File: rtl/arilla_bus_rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Rotating-priority request picker. The master just after ptr has the
//   highest priority and ptr itself the lowest.
// Ports
//   req   in  NumMasters  request vector
//   ptr   in  IdxW        rotation pointer (scan begins at ptr+1)
//   grant out NumMasters  one-hot winner, all zero when nothing requests
//   idx   out IdxW        index of the winner (0 when found=0)
//   found out 1           at least one request bit was set
// -----------------------------------------------------------------------------
module rr_priority_picker
    import arilla_bus_pkg::*;
#(
    parameter int unsigned NumMasters = 2
) (
    input  logic [NumMasters-1:0]         req,
    input  logic [$clog2(NumMasters)-1:0] ptr,
    output logic [NumMasters-1:0]         grant,
    output logic [$clog2(NumMasters)-1:0] idx,
    output logic                          found
);

    localparam int unsigned IdxW = $clog2(NumMasters);

    logic [RR_MAX_MASTERS-1:0] req_ext;
    rr_pick_t                  pick;
    logic                      pick_unused;

    // The helper returns a full-width index; only the low IdxW bits matter.
    assign pick_unused = ^pick.idx;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        req_ext                 = '0;
        req_ext[NumMasters-1:0] = req;
        pick                    = rr_next(req_ext, RR_IDX_W'(ptr), NumMasters);
        found                   = pick.found;
        idx                     = pick.found ? pick.idx[IdxW-1:0] : '0;
        grant                   = '0;
        if (pick.found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule : rr_priority_picker

// File: rtl/arilla_bus_arbiter.sv
// -----------------------------------------------------------------------------
// arilla_bus_arbiter
//   Shares one arilla bus slave port between NumMasters mem_interface masters.
//   The grant (available) is combinational from req/lock and registered
//   state, so a master completes its access in the grant cycle. The data
//   phase is tracked one cycle behind so data_ptc returns can be routed.
//   Round-robin with a per-owner burst limit, an atomic lock and optional
//   parking of the grant on the last owner when the bus is idle.
// Parameters
//   NumMasters  number of masters (>= 2); index 0 wins first after reset
//   MaxBurst    consecutive accesses one owner may take while others wait
//   ParkLast    1: keep the grant on the last owner when nobody requests
// Ports
//   clk           in  1           system clock
//   rst_n         in  1           asynchronous active-low reset
//   req           in  NumMasters  master i wants an access this cycle
//   lock          in  NumMasters  master i asks for exclusive ownership
//   available     out NumMasters  one-hot-or-zero grant
//   owner         out IdxW        current / parked owner
//   dphase_valid  out 1           an access was accepted last cycle
//   dphase_owner  out IdxW        master owning data_ptc this cycle
// -----------------------------------------------------------------------------
module arilla_bus_arbiter
    import arilla_bus_pkg::*;
#(
    parameter int unsigned NumMasters = 2,
    parameter int unsigned MaxBurst   = 4,
    parameter bit          ParkLast   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NumMasters-1:0]         req,
    input  logic [NumMasters-1:0]         lock,
    output logic [NumMasters-1:0]         available,
    output logic [$clog2(NumMasters)-1:0] owner,
    output logic                          dphase_valid,
    output logic [$clog2(NumMasters)-1:0] dphase_owner
);

    localparam int unsigned     IdxW    = $clog2(NumMasters);
    localparam int unsigned     CntW    = $clog2(MaxBurst + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxBurst);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [IdxW-1:0] LastRst = IdxW'(NumMasters - 1);

    // Registered state
    arb_state_e      state_q,        state_d;
    logic [IdxW-1:0] owner_q,        owner_d;
    logic [IdxW-1:0] last_q,         last_d;
    logic [CntW-1:0] burst_cnt_q,    burst_cnt_d;
    logic            dphase_valid_q, dphase_valid_d;
    logic [IdxW-1:0] dphase_owner_q, dphase_owner_d;

    // Combinational helpers
    logic [NumMasters-1:0] owner_oh;
    logic [NumMasters-1:0] last_oh;
    logic [NumMasters-1:0] pick_grant;
    logic [NumMasters-1:0] grant;
    logic [IdxW-1:0]       pick_ptr;
    logic [IdxW-1:0]       pick_idx;
    logic [IdxW-1:0]       grant_idx;
    logic                  pick_found;
    logic                  grant_valid;
    logic                  lock_held;
    logic                  others_req;
    logic                  accept;
    logic [CntW-1:0]       cnt_eff;

    assign owner_oh = {{(NumMasters-1){1'b0}}, 1'b1} << owner_q;
    assign last_oh  = {{(NumMasters-1){1'b0}}, 1'b1} << last_q;

    // While idle the rotation continues after the last owner; otherwise it
    // continues after the current owner, which therefore ranks last.
    assign pick_ptr = (state_q == ARB_IDLE) ? last_q : owner_q;

    rr_priority_picker #(
        .NumMasters (NumMasters)
    ) u_picker (
        .req   (req),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    always_comb begin
        lock_held   = (state_q == ARB_LOCKED) && lock[owner_q];
        // A lock that has just been released behaves as an exhausted burst so
        // that a waiting master gets the bus in this very cycle.
        cnt_eff     = (state_q == ARB_LOCKED) ? CntMax : burst_cnt_q;
        others_req  = |(req & ~owner_oh);
        grant       = '0;
        grant_idx   = owner_q;
        grant_valid = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant       = pick_grant;
                    grant_idx   = pick_idx;
                    grant_valid = 1'b1;
                end else if (ParkLast) begin
                    grant = last_oh;
                end
            end
            default: begin
                if (lock_held) begin
                    // Other masters are held off even if the owner is quiet.
                    grant       = owner_oh;
                    grant_valid = 1'b1;
                end else if (req[owner_q] && ((cnt_eff < CntMax) || !others_req)) begin
                    grant       = owner_oh;
                    grant_valid = 1'b1;
                end else if (pick_found) begin
                    grant       = pick_grant;
                    grant_idx   = pick_idx;
                    grant_valid = 1'b1;
                end else if (ParkLast) begin
                    grant = owner_oh;
                end
            end
        endcase

        // The grant is forced off during reset regardless of parking.
        available = rst_n ? grant : '0;
        accept    = rst_n && grant_valid && req[grant_idx];
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        burst_cnt_d    = burst_cnt_q;
        dphase_valid_d = accept;
        dphase_owner_d = accept ? grant_idx : dphase_owner_q;

        if (accept) begin
            if ((state_q != ARB_IDLE) && (grant_idx == owner_q)) begin
                burst_cnt_d = (cnt_eff < CntMax) ? (cnt_eff + CntOne) : CntMax;
            end else begin
                // From idle, last already names the previous owner.
                if (state_q != ARB_IDLE) begin
                    last_d = owner_q;
                end
                owner_d     = grant_idx;
                burst_cnt_d = CntOne;
            end
            // Only the master taking this access can turn its lock into LOCKED.
            state_d = lock[grant_idx] ? ARB_LOCKED : ARB_OWNED;
        end else if ((state_q == ARB_LOCKED) && !lock[owner_q]) begin
            state_d     = ARB_OWNED;
            burst_cnt_d = CntMax;
        end else if ((state_q == ARB_OWNED) && (req == '0)) begin
            state_d = ARB_IDLE;
            last_d  = owner_q;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            owner_q        <= '0;
            last_q         <= LastRst;
            burst_cnt_q    <= '0;
            dphase_valid_q <= 1'b0;
            dphase_owner_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            burst_cnt_q    <= burst_cnt_d;
            dphase_valid_q <= dphase_valid_d;
            dphase_owner_q <= dphase_owner_d;
        end
    end

    assign owner        = owner_q;
    assign dphase_valid = dphase_valid_q;
    assign dphase_owner = dphase_owner_q;

endmodule : arilla_bus_arbiter

// File: tb/tb_arilla_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_arilla_bus_arbiter
//   Directed bench for arilla_bus_arbiter. Instance A: 2 masters, burst 4,
//   parking on. Instance B: 3 masters, burst 1, parking off.
//   Inputs change 2 ns after a rising edge; outputs are sampled 2-3 ns after
//   the rising edge, well clear of the next one.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arilla_bus_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req_a, lock_a, avail_a;
    logic       owner_a, dv_a, do_a;
    logic [2:0] req_b, lock_b, avail_b;
    logic [1:0] owner_b, do_b;
    logic       dv_b;

    int n_cmp = 0;
    int n_err = 0;

    arilla_bus_arbiter #(.NumMasters(2), .MaxBurst(4), .ParkLast(1'b1)) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_a),
        .lock         (lock_a),
        .available    (avail_a),
        .owner        (owner_a),
        .dphase_valid (dv_a),
        .dphase_owner (do_a)
    );

    arilla_bus_arbiter #(.NumMasters(3), .MaxBurst(1), .ParkLast(1'b0)) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_b),
        .lock         (lock_b),
        .available    (avail_b),
        .owner        (owner_b),
        .dphase_valid (dv_b),
        .dphase_owner (do_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] seq2;
        logic [8:0] seq5;
        seq2 = 10'b0011110000;   // grant index per cycle, bit k = cycle k
        seq5 = 9'b111111100;

        req_a  = '0;
        lock_a = '0;
        req_b  = '0;
        lock_b = '0;
        rst_n  = 1'b0;
        #3;

        // ---- 1: reset ----
        check("rst_avail_a", 32'(avail_a), 32'h0);
        check("rst_dv_a", 32'(dv_a), 32'h0);
        check("rst_avail_b", 32'(avail_b), 32'h0);
        tick();
        rst_n = 1'b1;
        settle();
        check("park_after_rst_a", 32'(avail_a), 32'h2);
        check("owner_after_rst_a", 32'(owner_a), 32'h0);
        check("dv_after_rst_a", 32'(dv_a), 32'h0);
        check("noparK_b", 32'(avail_b), 32'h0);

        req_a = 2'b11;
        settle();
        check("first_grant_a", 32'(avail_a), 32'h1);
        tick();
        check("dv_first_a", 32'(dv_a), 32'h1);
        check("do_first_a", 32'(do_a), 32'h0);
        rst_n = 1'b0;
        settle();
        check("midrst_avail_a", 32'(avail_a), 32'h0);
        check("midrst_dv_a", 32'(dv_a), 32'h0);
        req_a = 2'b00;
        tick();
        rst_n = 1'b1;
        settle();
        check("rerelease_park_a", 32'(avail_a), 32'h2);
        check("rerelease_dv_a", 32'(dv_a), 32'h0);

        // ---- 2: contention, burst of 4 each ----
        req_a = 2'b11;
        settle();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("contend_avail_%0d", k), 32'(avail_a), seq2[k] ? 32'h2 : 32'h1);
            check($sformatf("contend_onehot_%0d", k), 32'($onehot0(avail_a)), 32'h1);
            if (k == 0) begin
                check("contend_dv_0", 32'(dv_a), 32'h0);
            end else begin
                check($sformatf("contend_dv_%0d", k), 32'(dv_a), 32'h1);
                check($sformatf("contend_do_%0d", k), 32'(do_a), 32'(seq2[k-1]));
            end
            tick();
        end

        // ---- 3: uncontested burst, counter saturates ----
        // Owner 0 enters with two accesses already counted.
        req_a = 2'b01;
        settle();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("solo_avail_%0d", k), 32'(avail_a), 32'h1);
            tick();
            check($sformatf("solo_cnt_%0d", k), 32'(u_dut_a.burst_cnt_q),
                  (k + 3 > 4) ? 32'd4 : 32'(k + 3));
        end
        check("solo_owner", 32'(owner_a), 32'h0);

        // Going idle parks on the last owner.
        req_a = 2'b00;
        settle();
        check("idle_park_now", 32'(avail_a), 32'h1);
        tick();
        check("idle_park_next", 32'(avail_a), 32'h1);
        check("idle_dv", 32'(dv_a), 32'h0);

        // ---- 4: lock by the owner ----
        req_a  = 2'b01;
        lock_a = 2'b01;
        settle();
        check("lock_take", 32'(avail_a), 32'h1);
        tick();
        req_a = 2'b11;
        settle();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("locked_avail_%0d", k), 32'(avail_a), 32'h1);
            tick();
        end
        lock_a = 2'b00;
        settle();
        check("unlock_same_cycle", 32'(avail_a), 32'h2);
        tick();
        check("unlock_owner", 32'(owner_a), 32'h1);
        check("unlock_dv", 32'(dv_a), 32'h1);
        check("unlock_do", 32'(do_a), 32'h1);

        // ---- 5: foreign lock ignored until that master owns ----
        req_a = 2'b01;
        settle();
        check("foreign_rotate", 32'(avail_a), 32'h1);
        tick();
        lock_a = 2'b10;
        settle();
        check("foreign_keep0", 32'(avail_a), 32'h1);
        tick();
        req_a = 2'b11;
        settle();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("foreign_avail_%0d", k), 32'(avail_a), seq5[k] ? 32'h2 : 32'h1);
            tick();
        end
        check("foreign_owner", 32'(owner_a), 32'h1);
        lock_a = 2'b00;
        settle();
        check("foreign_unlock", 32'(avail_a), 32'h1);
        tick();
        check("foreign_owner_after", 32'(owner_a), 32'h0);

        // ---- 6: N=3, pure round-robin ----
        req_b = 3'b101;
        settle();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr3_avail_%0d", k), 32'(avail_b), (k % 2 == 0) ? 32'h1 : 32'h4);
            check($sformatf("rr3_m1_%0d", k), 32'(avail_b[1]), 32'h0);
            check($sformatf("rr3_onehot_%0d", k), 32'($onehot0(avail_b)), 32'h1);
            if (k == 0) begin
                check("rr3_dv_0", 32'(dv_b), 32'h0);
            end else begin
                check($sformatf("rr3_do_%0d", k), 32'(do_b), (k % 2 == 1) ? 32'h0 : 32'h2);
            end
            tick();
        end
        req_b = 3'b000;
        settle();
        check("rr3_idle_avail", 32'(avail_b), 32'h0);
        tick();
        check("rr3_idle_dv", 32'(dv_b), 32'h0);
        check("rr3_idle_owner", 32'(owner_b), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_arilla_bus_arbiter
